// File: rtl/rom_fsm_sequencer_pkg.sv
// Shared definitions for the ROM-implemented FSM sequencer: transaction phase
// codes and width helpers for the ROM address and data buses.
package rom_fsm_sequencer_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_ISSUE   = 2'd1,
    PH_WAIT    = 2'd2,
    PH_PRESENT = 2'd3
  } phase_t;

  // ROM address is {state, inputs}; ROM word is {next_state, outputs}.
  function automatic int rom_addr_width(input int state_width, input int input_width);
    return state_width + input_width;
  endfunction

  function automatic int rom_data_width(input int state_width, input int output_width);
    return state_width + output_width;
  endfunction

endpackage

// File: rtl/rom_fsm_sequencer.sv
// Sequencing stage for a ROM-implemented FSM: drives {state, inputs} to an external
// 1-cycle sync ROM and loads {next_state, outputs}. Optional macro: FSM_ILLEGAL_STATE_EN.
module rom_fsm_sequencer
  import rom_fsm_sequencer_pkg::*;
#(
  parameter int gInputWidth  = 2,
  parameter int gStateWidth  = 2,
  parameter int gOutputWidth = 4,
  parameter int gResetState  = 0,
  parameter int gNumStates   = 4
) (
  input  logic                                                  iClock,
  input  logic                                                  iReset,
  input  logic                                                  iInValid,
  output logic                                                  oInReady,
  input  logic [gInputWidth-1:0]                                iInputs,
  output logic [rom_addr_width(gStateWidth, gInputWidth)-1:0]  oRomAddress,
  input  logic [rom_data_width(gStateWidth, gOutputWidth)-1:0] iRomData,
  output logic                                                  oOutValid,
  input  logic                                                  iOutReady,
  output logic [gOutputWidth-1:0]                               oOutputs,
  output logic [gStateWidth-1:0]                                oState,
  output logic                                                  oError
);

  localparam int AddrWidth = rom_addr_width(gStateWidth, gInputWidth);
  localparam int DataWidth = rom_data_width(gStateWidth, gOutputWidth);
  localparam logic [gStateWidth-1:0] ResetState = gStateWidth'(gResetState);

  // A state count outside the encodable range makes the legality check meaningless.
  if (gNumStates < 1 || gNumStates > (1 << gStateWidth)) begin : g_num_states_check
    $error("rom_fsm_sequencer: gNumStates out of range for gStateWidth");
  end

  phase_t                   phase_reg;
  logic [gStateWidth-1:0]   state_reg;
  logic [gInputWidth-1:0]   inputs_reg;
  logic [gOutputWidth-1:0]  outputs_reg;
  logic [AddrWidth-1:0]     rom_address_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;

  logic [gStateWidth-1:0]   rom_next_state;
  logic [gOutputWidth-1:0]  rom_outputs;

  assign rom_next_state = iRomData[DataWidth-1 -: gStateWidth];
  assign rom_outputs    = iRomData[gOutputWidth-1:0];

`ifdef FSM_ILLEGAL_STATE_EN
  logic error_reg;
  logic state_illegal;

  assign state_illegal = 32'(rom_next_state) >= 32'(gNumStates);
  assign oError        = error_reg;
`else
  assign oError = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      phase_reg       <= PH_IDLE;
      state_reg       <= ResetState;
      inputs_reg      <= '0;
      outputs_reg     <= '0;
      rom_address_reg <= {ResetState, {gInputWidth{1'b0}}};
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
`ifdef FSM_ILLEGAL_STATE_EN
      error_reg       <= 1'b0;
`endif
    end else begin
      case (phase_reg)
        PH_IDLE: begin
          if (iInValid) begin
            inputs_reg      <= iInputs;
            rom_address_reg <= {state_reg, iInputs};
            in_ready_reg    <= 1'b0;
            phase_reg       <= PH_ISSUE;
          end
        end
        // ROM samples the stable address at the end of this cycle.
        PH_ISSUE: phase_reg <= PH_WAIT;
        PH_WAIT: begin
          out_valid_reg <= 1'b1;
          phase_reg     <= PH_PRESENT;
`ifdef FSM_ILLEGAL_STATE_EN
          if (state_illegal) begin
            state_reg       <= ResetState;
            outputs_reg     <= '0;
            rom_address_reg <= {ResetState, inputs_reg};
            error_reg       <= 1'b1;
          end else
`endif
          begin
            state_reg       <= rom_next_state;
            outputs_reg     <= rom_outputs;
            rom_address_reg <= {rom_next_state, inputs_reg};
          end
        end
        PH_PRESENT: begin
          if (iOutReady) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            phase_reg     <= PH_IDLE;
          end
        end
        default: phase_reg <= PH_IDLE;
      endcase
    end
  end

  assign oInReady    = in_ready_reg;
  assign oOutValid   = out_valid_reg;
  assign oOutputs    = outputs_reg;
  assign oState      = state_reg;
  assign oRomAddress = rom_address_reg;

endmodule

// File: tb/tb_rom_fsm_sequencer.sv
// Directed bench for rom_fsm_sequencer with a behavioural 1-cycle sync ROM.
// Expectations follow FSM_ILLEGAL_STATE_EN when it is defined for the build.
module tb_rom_fsm_sequencer;

  logic       clk = 1'b0;
  logic       srst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] inputs;
  logic [3:0] rom_address;
  logic [5:0] rom_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] outputs;
  logic [1:0] state;
  logic       error;

  logic [5:0] rom [16];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_address];

  rom_fsm_sequencer #(
    .gInputWidth (2),
    .gStateWidth (2),
    .gOutputWidth(4),
    .gResetState (0),
    .gNumStates  (3)
  ) dut (
    .iClock     (clk),
    .iReset     (srst),
    .iInValid   (in_valid),
    .oInReady   (in_ready),
    .iInputs    (inputs),
    .oRomAddress(rom_address),
    .iRomData   (rom_data),
    .oOutValid  (out_valid),
    .iOutReady  (out_ready),
    .oOutputs   (outputs),
    .oState     (state),
    .oError     (error)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs of the 8-transaction walk from state 0, hand-derived from the table below.
  logic [1:0] seq_in  [8] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0};
  logic [3:0] seq_out [8] = '{4'hA, 4'hC, 4'h9, 4'h4, 4'hB, 4'h7, 4'h7, 4'h5};
  logic [1:0] seq_st  [8] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2};

  initial begin
    // {next_state, outputs} indexed by {state, inputs}
    rom[0]  = {2'd0, 4'h1}; rom[1]  = {2'd2, 4'hA}; rom[2]  = {2'd1, 4'h3}; rom[3]  = {2'd2, 4'h4};
    rom[4]  = {2'd2, 4'h5}; rom[5]  = {2'd0, 4'h6}; rom[6]  = {2'd1, 4'h7}; rom[7]  = {2'd2, 4'h8};
    rom[8]  = {2'd0, 4'h9}; rom[9]  = {2'd1, 4'hB}; rom[10] = {2'd2, 4'hC}; rom[11] = {2'd0, 4'hD};
    rom[12] = {2'd0, 4'hE}; rom[13] = {2'd0, 4'hE}; rom[14] = {2'd0, 4'hE}; rom[15] = {2'd0, 4'hE};

    srst = 1'b1; in_valid = 1'b0; inputs = 2'd0; out_ready = 1'b0;

    // Reset held for two cycles
    repeat (2) step();
    check_vec("rst_in_ready", 32'(in_ready), 32'd1);
    check_vec("rst_out_valid", 32'(out_valid), 32'd0);
    check_vec("rst_state", 32'(state), 32'd0);
    check_vec("rst_outputs", 32'(outputs), 32'd0);
    check_vec("rst_rom_addr", 32'(rom_address), 32'd0);
    check_vec("rst_error", 32'(error), 32'd0);
    srst = 1'b0;
    step();

    // Single transaction, latency N -> N+3
    in_valid = 1'b1; inputs = 2'b01;
    step();
    in_valid = 1'b0;
    check_vec("t2_rom_addr_n1", 32'(rom_address), 32'h1);
    check_vec("t2_in_ready_n1", 32'(in_ready), 32'd0);
    step();
    check_vec("t2_out_valid_n2", 32'(out_valid), 32'd0);
    step();
    check_vec("t2_out_valid_n3", 32'(out_valid), 32'd1);
    check_vec("t2_outputs_n3", 32'(outputs), 32'hA);
    check_vec("t2_state_n3", 32'(state), 32'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_vec("t2_idle_out_valid", 32'(out_valid), 32'd0);
    check_vec("t2_idle_in_ready", 32'(in_ready), 32'd1);

    // Backpressure in PRESENT with a pending input word
    in_valid = 1'b1; inputs = 2'b10;
    step();
    inputs = 2'b11;
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      check_vec($sformatf("t3_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
      check_vec($sformatf("t3_hold%0d_outputs", i), 32'(outputs), 32'hC);
      check_vec($sformatf("t3_hold%0d_state", i), 32'(state), 32'd2);
      check_vec($sformatf("t3_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      if (i < 4) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_vec("t3_release_in_ready", 32'(in_ready), 32'd1);
    check_vec("t3_release_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check_vec("t3_next_rom_addr", 32'(rom_address), 32'hB);
    repeat (2) step();
    check_vec("t3_next_outputs", 32'(outputs), 32'hD);
    check_vec("t3_next_state", 32'(state), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during WAIT discards the in-flight ROM word
    in_valid = 1'b1; inputs = 2'b11;
    step();
    in_valid = 1'b0;
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    check_vec("t4_in_ready", 32'(in_ready), 32'd1);
    check_vec("t4_out_valid", 32'(out_valid), 32'd0);
    check_vec("t4_state", 32'(state), 32'd0);
    check_vec("t4_outputs", 32'(outputs), 32'd0);
    repeat (3) step();
    check_vec("t4_later_out_valid", 32'(out_valid), 32'd0);
    check_vec("t4_later_outputs", 32'(outputs), 32'd0);

    // Streaming: one result every 4 cycles with both handshakes held high
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      inputs = seq_in[k];
      check_vec($sformatf("t6_tx%0d_in_ready", k), 32'(in_ready), 32'd1);
      repeat (3) step();
      check_vec($sformatf("t6_tx%0d_out_valid", k), 32'(out_valid), 32'd1);
      check_vec($sformatf("t6_tx%0d_outputs", k), 32'(outputs), 32'(seq_out[k]));
      check_vec($sformatf("t6_tx%0d_state", k), 32'(state), 32'(seq_st[k]));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Illegal next_state (3 with gNumStates=3) from state 2, input 3
    rom[11] = {2'd3, 4'hF};
    in_valid = 1'b1; inputs = 2'b11;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    check_vec("t5_out_valid", 32'(out_valid), 32'd1);
`ifdef FSM_ILLEGAL_STATE_EN
    check_vec("t5_state", 32'(state), 32'd0);
    check_vec("t5_outputs", 32'(outputs), 32'd0);
    check_vec("t5_error", 32'(error), 32'd1);
`else
    check_vec("t5_state", 32'(state), 32'd3);
    check_vec("t5_outputs", 32'(outputs), 32'hF);
    check_vec("t5_error", 32'(error), 32'd0);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; inputs = 2'b00;
    step();
    in_valid = 1'b0;
    repeat (2) step();
`ifdef FSM_ILLEGAL_STATE_EN
    check_vec("t5_sticky_outputs", 32'(outputs), 32'h1);
    check_vec("t5_sticky_error", 32'(error), 32'd1);
`else
    check_vec("t5_sticky_outputs", 32'(outputs), 32'hE);
    check_vec("t5_sticky_error", 32'(error), 32'd0);
`endif
    srst = 1'b1;
    step();
    srst = 1'b0;
    check_vec("t5_rst_error", 32'(error), 32'd0);
    check_vec("t5_rst_state", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
